// File: rtl/k_aud_cmprs_pkg.sv
// Shared constants and types for the audio compressor band-energy path.
package k_aud_cmprs_pkg;

  localparam int unsigned DEF_FFT_NUM_PTS = 16;
  localparam int unsigned DEF_NUM_BANDS   = 4;
  localparam int unsigned BPB_LOG2        = $clog2(DEF_FFT_NUM_PTS / DEF_NUM_BANDS);
  localparam int unsigned BAND_IDX_W      = $clog2(DEF_NUM_BANDS);

  typedef logic [BAND_IDX_W-1:0] band_idx_t;

  // Band reader state: waiting for a full bank, or streaming one out.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  // clog2 that never yields a zero-width vector.
  function automatic int unsigned safe_clog2(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/k_band_energy_accum_if.sv
// AXI-stream band-energy output bus.
interface k_band_energy_accum_if #(
  parameter int unsigned OUT_WIDTH = 48
);
  logic [OUT_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/k_band_energy_accum_reader.sv
// Drains full accumulator banks onto the AXI-stream, band 0 first, tlast on the final band.
module k_band_energy_accum_reader
  import k_aud_cmprs_pkg::*;
#(
  parameter int unsigned NUM_BANDS = DEF_NUM_BANDS,
  parameter int unsigned OUT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 aresetn,
  // bank is full now or becomes full on this edge
  input  logic [1:0]           avail_i,
  // next-state view of the banks, so a bank completing on this edge can be loaded at once
  input  logic [OUT_WIDTH-1:0] acc_i [2][NUM_BANDS],
  output logic [1:0]           clear_c_o,
  k_band_energy_accum_if.master m_axis
);

  localparam int unsigned BAND_W = safe_clog2(NUM_BANDS);

  rd_state_e            state_q;
  logic                 rd_bank_q;
  logic [BAND_W-1:0]    band_q;
  logic [OUT_WIDTH-1:0] tdata_q;
  logic                 tvalid_q;
  logic                 tlast_q;

  logic                 hs_c;
  logic [BAND_W-1:0]    nxt_band_c;

  assign hs_c       = tvalid_q && m_axis.tready;
  assign nxt_band_c = BAND_W'(band_q + 1'b1);

  // Release the bank on the handshake of its last band.
  always_comb begin
    clear_c_o = 2'b00;
    if ((state_q == RD_SEND) && hs_c && tlast_q) begin
      clear_c_o[rd_bank_q] = 1'b1;
    end
  end

  // Reader FSM with registered AXIS outputs; data only moves on handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      band_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (avail_i[rd_bank_q]) begin
            state_q  <= RD_SEND;
            band_q   <= '0;
            tdata_q  <= acc_i[rd_bank_q][0];
            tvalid_q <= 1'b1;
            tlast_q  <= (NUM_BANDS == 1);
          end
        end
        RD_SEND: begin
          if (hs_c) begin
            if (tlast_q) begin
              rd_bank_q <= ~rd_bank_q;
              band_q    <= '0;
              if (avail_i[~rd_bank_q]) begin
                tdata_q  <= acc_i[~rd_bank_q][0];
                tvalid_q <= 1'b1;
                tlast_q  <= (NUM_BANDS == 1);
              end else begin
                state_q  <= RD_IDLE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
              end
            end else begin
              band_q  <= nxt_band_c;
              tdata_q <= acc_i[rd_bank_q][nxt_band_c];
              tlast_q <= (nxt_band_c == BAND_W'(NUM_BANDS - 1));
            end
          end
        end
        default: begin
          state_q  <= RD_IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

endmodule

// File: rtl/k_band_energy_accum.sv
// Per-frame band energy accumulator, double-banked, streaming band totals over AXIS.
module k_band_energy_accum
  import k_aud_cmprs_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 40,
  parameter int unsigned FFT_NUM_PTS = DEF_FFT_NUM_PTS,
  parameter int unsigned NUM_BANDS   = DEF_NUM_BANDS,
  parameter int unsigned OUT_WIDTH   = 48
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [IN_WIDTH-1:0] energy_in,
  input  logic                energy_valid,
  input  logic                energy_sof,
  k_band_energy_accum_if.master m_axis,
  output logic                frame_dropped
);

  localparam int unsigned BIN_W  = safe_clog2(FFT_NUM_PTS);
  localparam int unsigned BAND_W = safe_clog2(NUM_BANDS);
  localparam int unsigned BPB    = FFT_NUM_PTS / NUM_BANDS;
  localparam int unsigned BPB_L2 = $clog2(BPB);

  logic [BIN_W-1:0]     bin_cnt_q, bin_cnt_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [1:0]           full_q, full_d;
  logic                 discard_q, discard_d;
  logic                 dropped_q, dropped_d;
  logic [OUT_WIDTH-1:0] acc_q [2][NUM_BANDS];
  logic [OUT_WIDTH-1:0] acc_d [2][NUM_BANDS];

  logic [BIN_W-1:0]     eff_bin_c;
  logic [BAND_W-1:0]    band_c;
  logic                 first_c;
  logic                 last_c;
  logic                 discard_c;
  logic [1:0]           full_set_c;
  logic [1:0]           rd_clear_c;

  // Bin decode: sof forces bin 0; a frame is judged for drop when its bin 0 arrives.
  always_comb begin
    eff_bin_c = energy_sof ? '0 : bin_cnt_q;
    band_c    = BAND_W'(eff_bin_c >> BPB_L2);
    first_c   = (eff_bin_c & BIN_W'(BPB - 1)) == '0;
    last_c    = (eff_bin_c == BIN_W'(FFT_NUM_PTS - 1));
    discard_c = (eff_bin_c == '0) ? full_q[wr_bank_q] : discard_q;
  end

  // Accumulate into the write bank, close frames, track drops.
  always_comb begin
    acc_d      = acc_q;
    bin_cnt_d  = bin_cnt_q;
    wr_bank_d  = wr_bank_q;
    discard_d  = discard_q;
    dropped_d  = dropped_q;
    full_set_c = 2'b00;
    if (energy_valid) begin
      bin_cnt_d = BIN_W'(eff_bin_c + 1'b1);
      discard_d = discard_c;
      if (discard_c) begin
        if (eff_bin_c == '0) begin
          dropped_d = 1'b1;
        end
      end else begin
        acc_d[wr_bank_q][band_c] = (first_c ? '0 : acc_q[wr_bank_q][band_c])
                                   + OUT_WIDTH'(energy_in);
        if (last_c) begin
          full_set_c[wr_bank_q] = 1'b1;
          wr_bank_d             = ~wr_bank_q;
        end
      end
    end
    // set and clear always target different banks
    full_d = (full_q | full_set_c) & ~rd_clear_c;
  end

  // Writer-side state registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bin_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      discard_q <= 1'b0;
      dropped_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < int'(NUM_BANDS); k++) begin
          acc_q[b][k] <= '0;
        end
      end
    end else begin
      bin_cnt_q <= bin_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      discard_q <= discard_d;
      dropped_q <= dropped_d;
      acc_q     <= acc_d;
    end
  end

  assign frame_dropped = dropped_q;

  k_band_energy_accum_reader #(
    .NUM_BANDS (NUM_BANDS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_reader (
    .clk       (clk),
    .aresetn   (aresetn),
    .avail_i   (full_q | full_set_c),
    .acc_i     (acc_d),
    .clear_c_o (rd_clear_c),
    .m_axis    (m_axis)
  );

endmodule

// File: tb/tb_k_band_energy_accum.sv
// Directed self-checking bench for k_band_energy_accum.
module tb_k_band_energy_accum;

  logic        clk;
  logic        aresetn;
  logic [39:0] energy_in;
  logic        energy_valid;
  logic        energy_sof;
  logic        frame_dropped;

  int checks;
  int errors;

  logic [47:0] q_data[$];
  logic        q_last[$];

  k_band_energy_accum_if #(.OUT_WIDTH(48)) m_axis ();

  k_band_energy_accum dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .energy_in     (energy_in),
    .energy_valid  (energy_valid),
    .energy_sof    (energy_sof),
    .m_axis        (m_axis),
    .frame_dropped (frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture each handshake; values at negedge are what the next posedge accepts.
  always @(negedge clk) begin
    if (aresetn && m_axis.tvalid && m_axis.tready) begin
      q_data.push_back(m_axis.tdata);
      q_last.push_back(m_axis.tlast);
    end
  end

  task automatic drive_bin(input logic [39:0] e, input logic sof);
    energy_in    = e;
    energy_valid = 1'b1;
    energy_sof   = sof;
    @(posedge clk); #1;
    energy_valid = 1'b0;
    energy_sof   = 1'b0;
  endtask

  // mode 0: every bin = val; mode 1: bin index
  task automatic send_frame(input int mode, input logic [39:0] val);
    for (int i = 0; i < 16; i++) begin
      drive_bin((mode == 1) ? 40'(i) : val, i == 0);
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!ok && q_data.size() >= n) ok = 1'b1;
      if (!ok) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    aresetn = 1'b0; energy_in = '0; energy_valid = 1'b0; energy_sof = 1'b0;
    m_axis.tready = 1'b1;
    #12;
    checks++;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", m_axis.tvalid); end
    checks++;
    if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b exp 0", m_axis.tlast); end
    checks++;
    if (m_axis.tdata !== 48'h0) begin errors++; $display("FAIL reset_tdata got %0h exp 0", m_axis.tdata); end
    checks++;
    if (frame_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %0b exp 0", frame_dropped); end
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones;
    bit ok;
    q_data.delete(); q_last.delete();
    m_axis.tready = 1'b1;
    for (int i = 0; i < 15; i++) drive_bin(40'd1, i == 0);
    checks++;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL ones_early_tvalid got %0b exp 0", m_axis.tvalid); end
    drive_bin(40'd1, 1'b0);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 48'd4) begin
      errors++; $display("FAIL ones_latency tvalid %0b tdata %0d exp 1/4", m_axis.tvalid, m_axis.tdata);
    end
    wait_words(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ones_timeout got %0d words exp 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 48'd4 || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL ones_word%0d got %0d/%0b exp 4/%0b", i, q_data[i], q_last[i], i == 3);
      end
    end
  endtask

  task automatic test_index_and_max;
    bit ok;
    logic [47:0] exp_w [8];
    exp_w = '{48'd6, 48'd22, 48'd38, 48'd54,
              48'h03FF_FFFF_FFFC, 48'h03FF_FFFF_FFFC, 48'h03FF_FFFF_FFFC, 48'h03FF_FFFF_FFFC};
    q_data.delete(); q_last.delete();
    send_frame(1, 40'd0);
    send_frame(0, 40'hFF_FFFF_FFFF);
    wait_words(8, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL index_timeout got %0d words exp 8", q_data.size()); end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_w[i] || q_last[i] !== ((i % 4) == 3)) begin
        errors++; $display("FAIL index_word%0d got %0h/%0b exp %0h/%0b", i, q_data[i], q_last[i], exp_w[i], (i % 4) == 3);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    logic        pv, pr, pl;
    logic [47:0] pd;
    logic [47:0] exp_w [4];
    exp_w = '{48'd6, 48'd22, 48'd38, 48'd54};
    q_data.delete(); q_last.delete();
    m_axis.tready = 1'b0;
    send_frame(1, 40'd0);
    for (int i = 0; i < 16; i++) begin
      pv = m_axis.tvalid; pd = m_axis.tdata; pl = m_axis.tlast; pr = m_axis.tready;
      @(posedge clk); #1;
      if (pv && !pr) begin
        checks++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== pd || m_axis.tlast !== pl) begin
          errors++; $display("FAIL stall_hold cyc %0d got %0b/%0d/%0b exp 1/%0d/%0b",
                             i, m_axis.tvalid, m_axis.tdata, m_axis.tlast, pd, pl);
        end
      end
      m_axis.tready = ~m_axis.tready;
    end
    m_axis.tready = 1'b1;
    wait_words(4, ok);
    idle(4);
    checks++;
    if (!ok || q_data.size() != 4) begin errors++; $display("FAIL stall_count got %0d words exp 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_w[i] || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL stall_word%0d got %0d/%0b exp %0d/%0b", i, q_data[i], q_last[i], exp_w[i], i == 3);
      end
    end
  endtask

  task automatic test_sof_restart;
    bit ok;
    logic [47:0] exp_w [4];
    exp_w = '{48'd6, 48'd22, 48'd38, 48'd54};
    q_data.delete(); q_last.delete();
    m_axis.tready = 1'b1;
    for (int i = 0; i < 7; i++) drive_bin(40'd100, i == 0);
    send_frame(1, 40'd0);
    wait_words(4, ok);
    idle(10);
    checks++;
    if (!ok || q_data.size() != 4) begin errors++; $display("FAIL sof_count got %0d words exp 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_w[i] || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL sof_word%0d got %0d/%0b exp %0d/%0b", i, q_data[i], q_last[i], exp_w[i], i == 3);
      end
    end
    checks++;
    if (frame_dropped !== 1'b0) begin errors++; $display("FAIL sof_dropped got %0b exp 0", frame_dropped); end
  endtask

  task automatic test_back_to_back_drop;
    bit ok;
    q_data.delete(); q_last.delete();
    m_axis.tready = 1'b0;
    send_frame(0, 40'd1);
    send_frame(0, 40'd2);
    checks++;
    if (frame_dropped !== 1'b0) begin errors++; $display("FAIL drop_early got %0b exp 0", frame_dropped); end
    send_frame(0, 40'd3);
    checks++;
    if (frame_dropped !== 1'b1) begin errors++; $display("FAIL drop_flag got %0b exp 1", frame_dropped); end
    checks++;
    if (q_data.size() != 0) begin errors++; $display("FAIL drop_leak got %0d words exp 0", q_data.size()); end
    m_axis.tready = 1'b1;
    wait_words(8, ok);
    idle(20);
    checks++;
    if (!ok || q_data.size() != 8) begin errors++; $display("FAIL drop_count got %0d words exp 8", q_data.size()); end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== ((i < 4) ? 48'd4 : 48'd8) || q_last[i] !== ((i % 4) == 3)) begin
        errors++; $display("FAIL drop_word%0d got %0d/%0b exp %0d/%0b", i, q_data[i], q_last[i],
                           (i < 4) ? 4 : 8, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    bit ok;
    m_axis.tready = 1'b1;
    send_frame(0, 40'd1);
    @(posedge clk); #1;
    checks++;
    if (m_axis.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid got %0b exp 1", m_axis.tvalid); end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis.tvalid !== 1'b0 || frame_dropped !== 1'b0) begin
      errors++; $display("FAIL mid_async tvalid %0b dropped %0b exp 0/0", m_axis.tvalid, frame_dropped);
    end
    idle(2);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    q_data.delete(); q_last.delete();
    send_frame(0, 40'd2);
    wait_words(4, ok);
    idle(5);
    checks++;
    if (!ok || q_data.size() != 4) begin errors++; $display("FAIL mid_count got %0d words exp 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 48'd8 || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL mid_word%0d got %0d/%0b exp 8/%0b", i, q_data[i], q_last[i], i == 3);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ones();
    test_index_and_max();
    test_stall();
    test_sof_restart();
    test_back_to_back_drop();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
